// File: rtl/mpsoc_wb_uart_host.sv
// Wishbone initiator that programs a 16550-style UART after reset, then shuttles bytes
// between a tx/rx valid-ready stream pair and THR/RBR by polling LSR.
module mpsoc_wb_uart_host #(
    parameter logic [15:0] DIVISOR   = 16'd27,
    parameter logic [7:0]  LCR_VALUE = 8'h03,
    parameter int          TIMEOUT   = 16
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_ni,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    output logic [3:0] wb_sel_o,
    input  logic       wb_ack_i,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    input  logic       rx_ready_i,
    output logic       init_done_o,
    output logic       bus_err_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        INIT_DLAB, INIT_DLL, INIT_DLM, INIT_LCR, INIT_FCR,
        IDLE, POLL, READ_RBR, WRITE_THR
    } state_t;

    state_t        state, state_d;
    logic [TW-1:0] tmo_cnt;
    logic          tx_full, rx_full;
    logic [7:0]    tx_byte;
    logic          start, cyc_done, tmo_hit;
    logic [2:0]    adr_d;
    logic [7:0]    dat_d, rd_data;
    logic          we_d;

    assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT - 1));
    assign cyc_done   = wb_stb_o & (wb_ack_i | tmo_hit);
    // A timed-out read behaves as if the slave returned zero.
    assign rd_data    = wb_ack_i ? wb_dat_i : 8'h00;
    assign wb_cyc_o   = wb_stb_o;
    assign tx_ready_o = init_done_o & ~tx_full;
    assign rx_valid_o = rx_full;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state <= INIT_DLAB;
        else            state <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state;
        adr_d   = 3'd0;
        dat_d   = 8'h00;
        we_d    = 1'b0;
        start   = 1'b0;
        case (state)
            INIT_DLAB: begin
                adr_d = 3'd3; dat_d = 8'h80 | LCR_VALUE; we_d = 1'b1;
                if (cyc_done) state_d = INIT_DLL;
            end
            INIT_DLL: begin
                adr_d = 3'd0; dat_d = DIVISOR[7:0]; we_d = 1'b1;
                if (cyc_done) state_d = INIT_DLM;
            end
            INIT_DLM: begin
                adr_d = 3'd1; dat_d = DIVISOR[15:8]; we_d = 1'b1;
                if (cyc_done) state_d = INIT_LCR;
            end
            INIT_LCR: begin
                adr_d = 3'd3; dat_d = LCR_VALUE & 8'h7F; we_d = 1'b1;
                if (cyc_done) state_d = INIT_FCR;
            end
            INIT_FCR: begin
                adr_d = 3'd2; dat_d = 8'h07; we_d = 1'b1;
                if (cyc_done) state_d = IDLE;
            end
            IDLE: begin
                if (!rx_full || tx_full) state_d = POLL;
            end
            POLL: begin
                adr_d = 3'd5;
                if (cyc_done) begin
                    if (rd_data[0] && !rx_full)     state_d = READ_RBR;
                    else if (rd_data[5] && tx_full) state_d = WRITE_THR;
                    else                            state_d = IDLE;
                end
            end
            READ_RBR: begin
                adr_d = 3'd0;
                if (cyc_done) state_d = IDLE;
            end
            WRITE_THR: begin
                adr_d = 3'd0; dat_d = tx_byte; we_d = 1'b1;
                if (cyc_done) state_d = IDLE;
            end
            default: state_d = INIT_DLAB;
        endcase
        // Every non-IDLE state owns one bus cycle; launching only from stb=0 forces the idle gap.
        if (state != IDLE && !wb_stb_o) start = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wb_stb_o <= 1'b0;
            wb_sel_o <= 4'b0000;
            wb_adr_o <= 3'd0;
            wb_dat_o <= 8'h00;
            wb_we_o  <= 1'b0;
            tmo_cnt  <= '0;
            bus_err_o <= 1'b0;
        end else if (start) begin
            wb_stb_o <= 1'b1;
            wb_sel_o <= 4'b0001;
            wb_adr_o <= adr_d;
            wb_dat_o <= dat_d;
            wb_we_o  <= we_d;
            tmo_cnt  <= '0;
        end else if (cyc_done) begin
            wb_stb_o <= 1'b0;
            wb_sel_o <= 4'b0000;
            wb_adr_o <= 3'd0;
            wb_dat_o <= 8'h00;
            wb_we_o  <= 1'b0;
            tmo_cnt  <= '0;
            if (!wb_ack_i) bus_err_o <= 1'b1;
        end else if (wb_stb_o) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            init_done_o <= 1'b0;
            tx_full     <= 1'b0;
            tx_byte     <= 8'h00;
            rx_full     <= 1'b0;
            rx_data_o   <= 8'h00;
        end else begin
            if (state == INIT_FCR && cyc_done) init_done_o <= 1'b1;

            if (state == WRITE_THR && cyc_done) begin
                tx_full <= 1'b0;
            end else if (tx_valid_i && tx_ready_o) begin
                tx_full <= 1'b1;
                tx_byte <= tx_data_i;
            end

            if (state == READ_RBR && cyc_done) begin
                rx_full   <= 1'b1;
                rx_data_o <= rd_data;
            end else if (rx_full && rx_ready_i) begin
                rx_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mpsoc_wb_uart_host.sv
// Directed bench for mpsoc_wb_uart_host: a one-wait-state Wishbone slave model answers
// the host, and a scoreboard of expected non-poll bus cycles is checked on every ack.
module tb_mpsoc_wb_uart_host;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] wb_adr;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i = 8'h00;
    logic       wb_we, wb_stb, wb_cyc, wb_ack = 1'b0;
    logic [3:0] wb_sel;
    logic       tx_valid, tx_ready, rx_valid, rx_ready, init_done, bus_err;
    logic [7:0] tx_data, rx_data;

    always #5 clk = ~clk;

    mpsoc_wb_uart_host dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wb_adr_o   (wb_adr),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_we_o    (wb_we),
        .wb_stb_o   (wb_stb),
        .wb_cyc_o   (wb_cyc),
        .wb_sel_o   (wb_sel),
        .wb_ack_i   (wb_ack),
        .tx_valid_i (tx_valid),
        .tx_data_i  (tx_data),
        .tx_ready_o (tx_ready),
        .rx_valid_o (rx_valid),
        .rx_data_o  (rx_data),
        .rx_ready_i (rx_ready),
        .init_done_o(init_done),
        .bus_err_o  (bus_err)
    );

    typedef struct {
        logic       we;
        logic [2:0] adr;
        logic [7:0] dat;
    } txn_t;

    txn_t sb[$];
    txn_t mon_e;
    int   n_asserts = 0;
    int   n_fail    = 0;
    int   cnt;
    logic found;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_txn(input logic we, input logic [2:0] adr, input logic [7:0] dat);
        txn_t t;
        t.we = we; t.adr = adr; t.dat = dat;
        sb.push_back(t);
    endtask

    task automatic push_init(input logic with_dlab);
        if (with_dlab) push_txn(1'b1, 3'd3, 8'h83);
        push_txn(1'b1, 3'd0, 8'h1B);
        push_txn(1'b1, 3'd1, 8'h00);
        push_txn(1'b1, 3'd3, 8'h03);
        push_txn(1'b1, 3'd2, 8'h07);
    endtask

    // Slave model: acks in the second cycle of each strobe; read data from LSR or RBR values.
    logic       slave_en = 1'b1;
    logic [7:0] lsr_val  = 8'h60;
    logic [7:0] rbr_val  = 8'h3C;
    always @(posedge clk) begin
        wb_ack   <= slave_en && wb_stb && !wb_ack;
        wb_dat_i <= (wb_adr == 3'd5) ? lsr_val : rbr_val;
    end

    // Bus monitor: protocol checks each cycle, scoreboard pop on every acked non-poll cycle.
    logic prev_ack = 1'b0;
    always @(negedge clk) begin
        if (prev_ack) check(32'(wb_stb), 32'd0, "idle_gap");
        if (wb_stb) begin
            check(32'(wb_cyc), 32'd1, "cyc_eq_stb");
            check(32'(wb_sel), 32'd1, "sel_during_cycle");
        end
        if (wb_stb && wb_ack && (wb_we || wb_adr != 3'd5)) begin
            check(32'(sb.size() != 0), 32'd1, "sb_cycle_expected");
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check(32'({wb_we, wb_adr}), 32'({mon_e.we, mon_e.adr}), "bus_we_adr");
                if (mon_e.we) check(32'(wb_dat_o), 32'(mon_e.dat), "bus_wdata");
            end
        end
        prev_ack = wb_stb && wb_ack;
    end

    task automatic wait_init(input string tag);
        for (int i = 0; i < 400 && !init_done; i++) @(negedge clk);
        check(32'(init_done), 32'd1, tag);
        check(32'(sb.size()), 32'd0, {tag, "_writes_drained"});
    endtask

    task automatic wait_tx_ready(input string tag);
        for (int i = 0; i < 400 && !tx_ready; i++) @(negedge clk);
        check(32'(tx_ready), 32'd1, tag);
    endtask

    task automatic send_tx(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        wait_tx_ready("tx_ready_offer");
        @(posedge clk);
        #1 tx_valid = 1'b0;
        check(32'(tx_ready), 32'd0, "tx_ready_drop");
    endtask

    initial begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check(32'({wb_stb, wb_cyc, wb_we, tx_ready, rx_valid, init_done, bus_err}), 32'd0, "reset_ctrl");
        check(32'({wb_sel, wb_adr, wb_dat_o, rx_data}), 32'd0, "reset_data");

        // Init sequence with a prompt slave.
        push_init(1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 400 && sb.size() > 1; i++) @(negedge clk);
        check(32'(init_done), 32'd0, "init_done_before_fcr");
        wait_init("init_done");
        check(32'(bus_err), 32'd0, "no_bus_err");
        check(32'(tx_ready), 32'd1, "tx_ready_after_init");

        // Single TX byte with LSR = 0x60.
        push_txn(1'b1, 3'd0, 8'hA5);
        send_tx(8'hA5);
        wait_tx_ready("tx_ready_back");
        check(32'(sb.size()), 32'd0, "tx_a5_written");

        // RX takes priority over a pending TX byte on the same LSR sample.
        lsr_val = 8'h00;
        repeat (4) @(negedge clk);
        push_txn(1'b0, 3'd0, 8'h00);
        push_txn(1'b1, 3'd0, 8'h5A);
        send_tx(8'h5A);
        lsr_val = 8'h61;
        for (int i = 0; i < 400 && !rx_valid; i++) @(negedge clk);
        check(32'(rx_valid), 32'd1, "rx_valid");
        check(32'(rx_data), 32'h3C, "rx_data");
        check(32'(tx_ready), 32'd0, "tx_held_behind_rx");
        wait_tx_ready("tx_ready_after_rx");
        check(32'(sb.size()), 32'd0, "rx_then_tx_done");

        // Held rx byte blocks further RBR reads.
        lsr_val = 8'h01;
        repeat (40) @(negedge clk);
        check(32'(rx_valid), 32'd1, "rx_hold_valid");
        check(32'(rx_data), 32'h3C, "rx_hold_data");
        lsr_val  = 8'h60;
        rbr_val  = 8'hC3;
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        check(32'(rx_valid), 32'd0, "rx_popped");
        repeat (20) @(negedge clk);

        // Slave silent on the first init write: cycle times out and init continues.
        rst_n = 1'b0;
        sb.delete();
        slave_en = 1'b0;
        @(negedge clk);
        check(32'({rx_valid, init_done, bus_err}), 32'd0, "reset2_state");
        push_init(1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20 && !wb_stb; i++) @(negedge clk);
        cnt = 0;
        while (wb_stb && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check(32'(cnt), 32'd16, "timeout_stb_cycles");
        check(32'(bus_err), 32'd1, "bus_err_set");
        slave_en = 1'b1;
        wait_init("init_after_timeout");
        check(32'(bus_err), 32'd1, "bus_err_sticky");

        // Reset during the THR write: strobe drops at once and init replays.
        send_tx(8'h77);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            found = wb_stb && wb_we && (wb_adr == 3'd0);
        end
        check(32'(found), 32'd1, "thr_write_seen");
        rst_n = 1'b0;
        #1;
        check(32'({wb_stb, wb_cyc, wb_sel}), 32'd0, "async_reset_drop");
        @(negedge clk);
        sb.delete();
        push_init(1'b1);
        rst_n = 1'b1;
        wait_init("init_replay");
        check(32'(tx_ready), 32'd1, "tx_byte_discarded");
        check(32'(bus_err), 32'd0, "bus_err_cleared");
        repeat (30) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
